// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl
// Description : Session sequencer for the 5-input voter. Opens a timed
//               voting session, latches one vote per voter, drives the
//               vote vector onto the voter, samples its Y output after a
//               settle window and holds the result for display.
// Revision    : 1.0 - initial release
// ============================================================================
module vote_session_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000,
  parameter int EVAL_CYC    = 2,
  parameter int SHOW_CYC    = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] vote_yes,
  input  logic [4:0] vote_no,
  input  logic       y_in,
  output logic [4:0] vote_o,
  output logic [4:0] voted,
  output logic [2:0] yes_count,
  output logic       busy,
  output logic       result,
  output logic       result_valid,
  output logic       timeout_flag
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // Terminal timer values for each timed phase
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] C_EVAL_LAST    = CNT_W'(EVAL_CYC - 1);
  localparam logic [CNT_W-1:0] C_SHOW_LAST    = CNT_W'(SHOW_CYC - 1);
  localparam logic [4:0]       C_ALL_VOTED    = 5'b11111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [4:0]       vote_o_q, vote_o_d;
  logic [4:0]       voted_q, voted_d;
  logic [2:0]       yes_count_q, yes_count_d;
  logic             busy_q, busy_d;
  logic             result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             timeout_flag_q, timeout_flag_d;

  // Next-state, vote latching and timer sequencing
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    vote_o_d       = vote_o_q;
    voted_d        = voted_q;
    result_d       = result_q;
    timeout_flag_d = timeout_flag_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = COLLECT;
          timer_d        = '0;
          vote_o_d       = '0;
          voted_d        = '0;
          result_d       = 1'b0;
          timeout_flag_d = 1'b0;
        end
      end

      COLLECT: begin
        // First unambiguous pulse per open voter wins; yes+no together is ignored
        for (int i = 0; i < 5; i++) begin
          if (!voted_q[i] && (vote_yes[i] ^ vote_no[i])) begin
            voted_d[i]  = 1'b1;
            vote_o_d[i] = vote_yes[i];
          end
        end
        timer_d = timer_q + 1'b1;
        if (voted_q == C_ALL_VOTED) begin
          state_d = EVAL;
          timer_d = '0;
        end else if (timer_q == C_TIMEOUT_LAST) begin
          // A vote completing the set in the final cycle beats the timeout
          state_d        = EVAL;
          timer_d        = '0;
          timeout_flag_d = (voted_d != C_ALL_VOTED);
        end
      end

      EVAL: begin
        if (timer_q == C_EVAL_LAST) begin
          result_d = y_in;
          state_d  = SHOW;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      SHOW: begin
        if (timer_q == C_SHOW_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Registered status outputs derived from the next-state vote vector and state
  always_comb begin
    yes_count_d = 3'd0;
    for (int i = 0; i < 5; i++) begin
      yes_count_d = yes_count_d + {2'b00, vote_o_d[i]};
    end
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == SHOW);
  end

  // State and output registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      vote_o_q       <= '0;
      voted_q        <= '0;
      yes_count_q    <= '0;
      busy_q         <= 1'b0;
      result_q       <= 1'b0;
      result_valid_q <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      vote_o_q       <= vote_o_d;
      voted_q        <= voted_d;
      yes_count_q    <= yes_count_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign vote_o       = vote_o_q;
  assign voted        = voted_q;
  assign yes_count    = yes_count_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_flag = timeout_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vote_session_ctrl
// Description : Directed self-checking bench for vote_session_ctrl with a
//               majority-of-5 voter model (overridable) on y_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vote_session_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] vote_yes;
  logic [4:0] vote_no;
  logic       y_in;
  logic [4:0] vote_o;
  logic [4:0] voted;
  logic [2:0] yes_count;
  logic       busy;
  logic       result;
  logic       result_valid;
  logic       timeout_flag;

  logic       force_en;
  logic       force_val;
  int         n_checks;
  int         n_err;

  vote_session_ctrl #(
    .CNT_W       (16),
    .TIMEOUT_CYC (20),
    .EVAL_CYC    (2),
    .SHOW_CYC    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vote_yes     (vote_yes),
    .vote_no      (vote_no),
    .y_in         (y_in),
    .vote_o       (vote_o),
    .voted        (voted),
    .yes_count    (yes_count),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .timeout_flag (timeout_flag)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Voter model: majority of five, with an override used for the sampling-point test
  always_comb y_in = force_en ? force_val : ($countones(vote_o) >= 3);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic vote(input logic [4:0] y, input logic [4:0] n);
    vote_yes = y;
    vote_no  = n;
    step();
    vote_yes = 5'b0;
    vote_no  = 5'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_rv(input int max_cyc);
    int n;
    n = 0;
    while (result_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n_rv;
    int guard;
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    vote_yes  = 5'b0;
    vote_no   = 5'b0;
    force_en  = 1'b0;
    force_val = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_vote_o", 8'(vote_o), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_flags", 8'({result, result_valid, timeout_flag, yes_count, voted}), 8'h00);
    rst_n = 1'b1;
    step();

    // Asynchronous abort mid-COLLECT after two votes
    do_start();
    chk("collect_busy", 8'(busy), 8'h01);
    vote(5'b10000, 5'b00000);
    vote(5'b00000, 5'b01000);
    chk("pre_abort_voted", 8'(voted), 8'h18);
    chk("pre_abort_yes", 8'(yes_count), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_voted", 8'(voted), 8'h00);
    chk("abort_vote_o", 8'(vote_o), 8'h00);
    chk("abort_outs", 8'({busy, yes_count, result, result_valid, timeout_flag}), 8'h00);
    step();
    rst_n = 1'b1;
    step();
    vote(5'b11111, 5'b00000);
    chk("idle_ignore_voted", 8'(voted), 8'h00);
    chk("idle_ignore_busy", 8'(busy), 8'h00);
    repeat (8) step();
    chk("abort_no_result", 8'({busy, result_valid}), 8'h00);

    // Full session: A,B,C yes; D,E no; start pulses while busy are ignored
    do_start();
    vote(5'b10000, 5'b00000);
    vote(5'b01000, 5'b00000);
    do_start();
    chk("lock_collect_voted", 8'(voted), 8'h18);
    vote(5'b00100, 5'b00000);
    vote(5'b00000, 5'b00010);
    vote(5'b00000, 5'b00001);
    chk("s1_vote_o", 8'(vote_o), 8'h1C);
    chk("s1_yes_count", 8'(yes_count), 8'h03);
    chk("s1_voted", 8'(voted), 8'h1F);
    step();
    do_start();
    chk("s1_rv_before", 8'(result_valid), 8'h00);
    step();
    chk("s1_rv_latency", 8'(result_valid), 8'h01);
    chk("s1_result", 8'(result), 8'h01);
    chk("s1_timeout", 8'(timeout_flag), 8'h00);
    n_rv = 1;
    do_start();
    if (result_valid === 1'b1) n_rv++;
    guard = 0;
    while (result_valid === 1'b1 && guard < 20) begin
      step();
      guard++;
      if (result_valid === 1'b1) n_rv++;
    end
    chk("s1_show_len", 8'(n_rv), 8'h04);
    chk("s1_idle_busy", 8'(busy), 8'h00);
    chk("s1_held_voted", 8'(voted), 8'h1F);
    chk("s1_held_result", 8'(result), 8'h01);

    // Only A yes, duplicate A vote, both-high on B
    do_start();
    chk("s2_clear_voted", 8'(voted), 8'h00);
    chk("s2_clear_result", 8'({result, yes_count, vote_o}), 8'h00);
    vote(5'b10000, 5'b00000);
    vote(5'b00000, 5'b10000);
    vote(5'b01000, 5'b01000);
    chk("s2_dup_vote_o", 8'(vote_o), 8'h10);
    chk("s2_both_voted", 8'(voted), 8'h10);
    vote(5'b00000, 5'b01111);
    chk("s2_vote_o", 8'(vote_o), 8'h10);
    chk("s2_yes_count", 8'(yes_count), 8'h01);
    wait_rv(20);
    chk("s2_rv", 8'(result_valid), 8'h01);
    chk("s2_result", 8'(result), 8'h00);
    wait_idle(20);

    // All five yes at once; y_in overridden only in the sampling cycle
    do_start();
    vote(5'b11111, 5'b00000);
    chk("s3_vote_o", 8'(vote_o), 8'h1F);
    chk("s3_yes_count", 8'(yes_count), 8'h05);
    step();
    step();
    force_en  = 1'b1;
    force_val = 1'b0;
    step();
    force_en  = 1'b0;
    chk("s3_rv_latency", 8'(result_valid), 8'h01);
    chk("s3_sample_point", 8'(result), 8'h00);
    wait_idle(20);

    // Timeout with only B yes: EVAL after 20 COLLECT cycles
    do_start();
    vote(5'b01000, 5'b00000);
    repeat (18) step();
    chk("to_not_yet", 8'({busy, timeout_flag}), 8'h02);
    step();
    chk("to_flag", 8'(timeout_flag), 8'h01);
    chk("to_vote_o", 8'(vote_o), 8'h08);
    chk("to_voted", 8'(voted), 8'h08);
    wait_rv(20);
    chk("to_result", 8'({result_valid, result}), 8'h02);
    wait_idle(20);
    chk("to_held_flag", 8'(timeout_flag), 8'h01);

    // Last vote lands in the final timeout cycle: all-voted path wins
    do_start();
    chk("s5_clear_flag", 8'(timeout_flag), 8'h00);
    vote(5'b11110, 5'b00000);
    repeat (18) step();
    chk("s5_still_collect", 8'({busy, voted}), 8'h3E);
    vote(5'b00000, 5'b00001);
    chk("s5_flag", 8'(timeout_flag), 8'h00);
    chk("s5_voted", 8'(voted), 8'h1F);
    chk("s5_yes_count", 8'(yes_count), 8'h04);
    wait_rv(20);
    chk("s5_result", 8'({result_valid, result, timeout_flag}), 8'h06);
    wait_idle(20);
    chk("s5_idle", 8'(busy), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
